// File: rtl/cpu_ctrl_if.sv
// Controller <-> datapath bus: PC, ROM port, ALU zero flag in; ROM address and datapath strobes out.
// master = the sequencing controller, slave = the PC/ROM/register-file/ALU side.
interface cpu_ctrl_if #(
   parameter int ADDR_WIDTH = 3
);
   logic                  run;
   logic [ADDR_WIDTH-1:0] pc;
   logic [7:0]            rom_data;
   logic                  alu_zero;

   logic [ADDR_WIDTH-1:0] rom_addr;
   logic                  pc_enable;
   logic                  pc_load;
   logic [ADDR_WIDTH-1:0] pc_next_value;
   logic [15:0]           ir;
   logic                  rf_we;
   logic [1:0]            rf_waddr;
   logic [1:0]            rf_raddr_a;
   logic [1:0]            rf_raddr_b;
   logic [2:0]            alu_op;
   logic                  alu_src_imm;
   logic [7:0]            imm;
   logic                  z_flag;
   logic                  halted;
   logic                  illegal_op;

   modport master (
      input  run, pc, rom_data, alu_zero,
      output rom_addr, pc_enable, pc_load, pc_next_value, ir,
             rf_we, rf_waddr, rf_raddr_a, rf_raddr_b,
             alu_op, alu_src_imm, imm, z_flag, halted, illegal_op
   );

   modport slave (
      output run, pc, rom_data, alu_zero,
      input  rom_addr, pc_enable, pc_load, pc_next_value, ir,
             rf_we, rf_waddr, rf_raddr_a, rf_raddr_b,
             alu_op, alu_src_imm, imm, z_flag, halted, illegal_op
   );
endinterface

// File: rtl/cpu_ctrl_fsm.sv
// Instruction sequencer for the 8-bit CPU: two-byte fetch, decode, one-cycle execute strobes.
// Define CTRL_ILLEGAL_TRAP_EN to trap opcodes A-E into HALT instead of treating them as NOP.
module cpu_ctrl_fsm #(
   parameter int ADDR_WIDTH = 3
) (
   input logic        clk,
   input logic        reset,
   cpu_ctrl_if.master bus
);

   typedef enum logic [2:0] {
      S_FETCH_HI,
      S_FETCH_LO,
      S_DECODE,
      S_EXECUTE,
      S_HALT
   } state_e;

   typedef enum logic [3:0] {
      OP_NOP = 4'h0,
      OP_LDI = 4'h1,
      OP_ADD = 4'h2,
      OP_SUB = 4'h3,
      OP_AND = 4'h4,
      OP_OR  = 4'h5,
      OP_MOV = 4'h6,
      OP_JMP = 4'h7,
      OP_JZ  = 4'h8,
      OP_JNZ = 4'h9,
      OP_HLT = 4'hF
   } opcode_e;

   typedef enum logic [2:0] {
      ALU_ADD    = 3'd0,
      ALU_SUB    = 3'd1,
      ALU_AND    = 3'd2,
      ALU_OR     = 3'd3,
      ALU_PASS_B = 3'd4
   } alu_op_e;

   state_e      state_q, state_d;
   logic [15:0] ir_q, ir_d;
   logic        z_q, z_d;
   logic        halted_q, halted_d;
`ifdef CTRL_ILLEGAL_TRAP_EN
   logic        illegal_q, illegal_d;
`endif

   logic [ADDR_WIDTH-1:0] rom_addr;
   logic                  pc_enable;
   logic                  pc_load;
   logic                  rf_we;
   alu_op_e               alu_op;
   logic                  alu_src_imm;

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= S_FETCH_HI;
         ir_q      <= '0;
         z_q       <= 1'b0;
         halted_q  <= 1'b0;
`ifdef CTRL_ILLEGAL_TRAP_EN
         illegal_q <= 1'b0;
`endif
      end else begin
         state_q   <= state_d;
         ir_q      <= ir_d;
         z_q       <= z_d;
         halted_q  <= halted_d;
`ifdef CTRL_ILLEGAL_TRAP_EN
         illegal_q <= illegal_d;
`endif
      end
   end

   // NOTE: every always_comb output gets a default first, so no path can infer a latch.
   always_comb begin
      state_d     = state_q;
      ir_d        = ir_q;
      z_d         = z_q;
      halted_d    = halted_q;
`ifdef CTRL_ILLEGAL_TRAP_EN
      illegal_d   = illegal_q;
`endif
      rom_addr    = bus.pc;
      pc_enable   = 1'b0;
      pc_load     = 1'b0;
      rf_we       = 1'b0;
      alu_op      = ALU_ADD;
      alu_src_imm = 1'b0;

      case (state_q)
         S_FETCH_HI: begin
            if (bus.run) state_d = S_FETCH_LO;
         end

         // ROM answers one cycle late: the byte arriving now is the high byte requested in FETCH_HI.
         S_FETCH_LO: begin
            rom_addr    = bus.pc + ADDR_WIDTH'(1);
            ir_d[15:8]  = bus.rom_data;
            state_d     = S_DECODE;
         end

         S_DECODE: begin
            ir_d[7:0] = bus.rom_data;
            state_d   = S_EXECUTE;
         end

         S_EXECUTE: begin
            state_d   = S_FETCH_HI;
            pc_enable = 1'b1;
            case (ir_q[15:12])
               OP_NOP: ;
               OP_LDI: begin
                  rf_we       = 1'b1;
                  alu_op      = ALU_PASS_B;
                  alu_src_imm = 1'b1;
               end
               OP_ADD: begin
                  rf_we  = 1'b1;
                  alu_op = ALU_ADD;
                  z_d    = bus.alu_zero;
               end
               OP_SUB: begin
                  rf_we  = 1'b1;
                  alu_op = ALU_SUB;
                  z_d    = bus.alu_zero;
               end
               OP_AND: begin
                  rf_we  = 1'b1;
                  alu_op = ALU_AND;
                  z_d    = bus.alu_zero;
               end
               OP_OR: begin
                  rf_we  = 1'b1;
                  alu_op = ALU_OR;
                  z_d    = bus.alu_zero;
               end
               OP_MOV: begin
                  rf_we  = 1'b1;
                  alu_op = ALU_PASS_B;
               end
               OP_JMP: pc_load = 1'b1;
               // Conditional branches see the flag left by an earlier instruction.
               OP_JZ:  pc_load = z_q;
               OP_JNZ: pc_load = ~z_q;
               OP_HLT: begin
                  pc_enable = 1'b0;
                  halted_d  = 1'b1;
                  state_d   = S_HALT;
               end
               default: begin
`ifdef CTRL_ILLEGAL_TRAP_EN
                  pc_enable = 1'b0;
                  illegal_d = 1'b1;
                  halted_d  = 1'b1;
                  state_d   = S_HALT;
`endif
               end
            endcase
         end

         S_HALT: ;

         default: state_d = S_FETCH_HI;
      endcase
   end

   assign bus.rom_addr      = rom_addr;
   assign bus.pc_enable     = pc_enable;
   assign bus.pc_load       = pc_load;
   assign bus.rf_we         = rf_we;
   assign bus.alu_op        = alu_op;
   assign bus.alu_src_imm   = alu_src_imm;

   // Branch targets are forced to an even (instruction-aligned) address.
   assign bus.pc_next_value = {ir_q[ADDR_WIDTH-1:1], 1'b0};
   assign bus.ir            = ir_q;
   assign bus.rf_waddr      = ir_q[11:10];
   assign bus.rf_raddr_a    = ir_q[11:10];
   assign bus.rf_raddr_b    = ir_q[9:8];
   assign bus.imm           = ir_q[7:0];
   assign bus.z_flag        = z_q;
   assign bus.halted        = halted_q;
`ifdef CTRL_ILLEGAL_TRAP_EN
   assign bus.illegal_op    = illegal_q;
`else
   assign bus.illegal_op    = 1'b0;
`endif

endmodule

// File: tb/tb_cpu_ctrl_fsm.sv
// Directed bench for cpu_ctrl_fsm with a behavioural PC and synchronous ROM around it.
// Expected values are hand-computed per step; the illegal-opcode step follows CTRL_ILLEGAL_TRAP_EN.
module tb_cpu_ctrl_fsm;
   localparam int AW = 3;

   logic clk = 1'b0;
   logic reset;
   int   n_checks = 0;
   int   n_fail   = 0;

   cpu_ctrl_if #(.ADDR_WIDTH(AW)) bus ();

   cpu_ctrl_fsm #(.ADDR_WIDTH(AW)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   logic [7:0] rom [8];

   always_ff @(posedge clk) bus.rom_data <= rom[bus.rom_addr];

   always_ff @(posedge clk or posedge reset) begin
      if (reset)              bus.pc <= '0;
      else if (bus.pc_enable) bus.pc <= bus.pc_load ? bus.pc_next_value : bus.pc + AW'(2);
   end

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_checks++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // pc_enable, pc_load, rf_we, alu_src_imm, alu_op all quiet
   task automatic chk_idle(input string tag);
      chk(tag, 16'({bus.pc_enable, bus.pc_load, bus.rf_we, bus.alu_src_imm, bus.alu_op}), 16'h0);
   endtask

   task automatic cyc();
      @(posedge clk);
      #2;
   endtask

   task automatic load(input logic [7:0] b0, b1, b2, b3, b4, b5, b6, b7);
      rom[0] = b0; rom[1] = b1; rom[2] = b2; rom[3] = b3;
      rom[4] = b4; rom[5] = b5; rom[6] = b6; rom[7] = b7;
   endtask

   // Hold reset across one edge, release it; DUT is then in FETCH_HI at pc=0.
   task automatic do_reset();
      reset = 1'b1;
      cyc();
      reset = 1'b0;
      #1;
   endtask

   initial begin
      reset        = 1'b1;
      bus.run      = 1'b1;
      bus.alu_zero = 1'b0;

      // LDI r1,7 ; SUB r1,r1 ; NOP ; JZ 0x04
      load(8'h15, 8'h07, 8'h35, 8'h00, 8'h00, 8'h00, 8'h80, 8'h04);
      cyc();
      chk("rst_ir", bus.ir, 16'h0000);
      chk("rst_flags", 16'({bus.z_flag, bus.halted, bus.illegal_op}), 16'h0);
      chk_idle("rst_strobes");
      chk("rst_addr", 16'(bus.rom_addr), 16'h0);
      reset = 1'b0;
      #1;
      chk("fhi_addr", 16'(bus.rom_addr), 16'h0);
      chk_idle("fhi_idle");
      cyc();
      chk("flo_addr", 16'(bus.rom_addr), 16'h1);
      chk_idle("flo_idle");
      cyc();
      chk("dec_ir", bus.ir, 16'h1500);
      chk("dec_addr", 16'(bus.rom_addr), 16'h0);
      cyc();
      chk("ldi_ir", bus.ir, 16'h1507);
      chk("ldi_ctl", 16'({bus.rf_we, bus.rf_waddr, bus.alu_src_imm, bus.alu_op}), 16'b1_01_1_100);
      chk("ldi_imm", 16'(bus.imm), 16'h0007);
      chk("ldi_pc", 16'({bus.pc_enable, bus.pc_load}), 16'b10);
      cyc();
      chk("ldi_next_pc", 16'(bus.pc), 16'h2);
      chk("ldi_next_addr", 16'(bus.rom_addr), 16'h2);
      chk_idle("ldi_after_idle");

      bus.alu_zero = 1'b1;
      cyc(); cyc(); cyc();
      chk("sub_ctl", 16'({bus.rf_we, bus.alu_src_imm, bus.alu_op}), 16'b1_0_001);
      chk("sub_z_before", 16'(bus.z_flag), 16'h0);
      cyc();
      chk("sub_z_after", 16'(bus.z_flag), 16'h1);
      chk("sub_next_pc", 16'(bus.pc), 16'h4);

      bus.alu_zero = 1'b0;
      cyc(); cyc(); cyc();
      chk("nop_ctl", 16'({bus.pc_enable, bus.pc_load, bus.rf_we, bus.alu_op}), 16'b1_0_0_000);
      cyc();
      chk("nop_z_hold", 16'(bus.z_flag), 16'h1);
      chk("nop_next_pc", 16'(bus.pc), 16'h6);
      cyc();
      chk("jz_lo_addr", 16'(bus.rom_addr), 16'h7);
      cyc(); cyc();
      chk("jz_taken", 16'({bus.pc_enable, bus.pc_load, bus.rf_we}), 16'b110);
      chk("jz_target", 16'(bus.pc_next_value), 16'h4);
      cyc();
      chk("jz_pc", 16'(bus.pc), 16'h4);

      // SUB (nonzero) ; JZ 0x04 ; JNZ 0x02
      load(8'h35, 8'h00, 8'h80, 8'h04, 8'h90, 8'h02, 8'h00, 8'h00);
      bus.alu_zero = 1'b0;
      do_reset();
      cyc(); cyc(); cyc(); cyc();
      chk("sub2_z", 16'(bus.z_flag), 16'h0);
      cyc(); cyc(); cyc();
      chk("jz_not_taken", 16'({bus.pc_enable, bus.pc_load}), 16'b10);
      cyc();
      chk("jz_nt_pc", 16'(bus.pc), 16'h4);
      cyc(); cyc(); cyc();
      chk("jnz_taken", 16'({bus.pc_enable, bus.pc_load}), 16'b11);
      chk("jnz_target", 16'(bus.pc_next_value), 16'h2);
      cyc();
      chk("jnz_pc", 16'(bus.pc), 16'h2);

      // SUB (zero) ; JNZ 0x00 ; JMP 0x05
      load(8'h35, 8'h00, 8'h90, 8'h00, 8'h70, 8'h05, 8'h00, 8'h00);
      bus.alu_zero = 1'b1;
      do_reset();
      cyc(); cyc(); cyc(); cyc();
      bus.alu_zero = 1'b0;
      chk("sub3_z", 16'(bus.z_flag), 16'h1);
      cyc(); cyc(); cyc();
      chk("jnz_not_taken", 16'({bus.pc_enable, bus.pc_load}), 16'b10);
      cyc(); cyc(); cyc(); cyc();
      chk("jmp_taken", 16'({bus.pc_enable, bus.pc_load}), 16'b11);
      chk("jmp_odd_target", 16'(bus.pc_next_value), 16'h4);
      cyc();
      chk("jmp_pc", 16'(bus.pc), 16'h4);

      // run pause, then NOP x3 and MOV r2,r3 at pc=6 wrapping to 0
      load(8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h6B, 8'h00);
      bus.run = 1'b0;
      do_reset();
      for (int i = 0; i < 5; i++) begin
         cyc();
         chk($sformatf("pause_%0d", i), 16'({bus.rom_addr, bus.pc_enable, bus.pc_load, bus.rf_we}), 16'h0);
      end
      chk("pause_ir", bus.ir, 16'h0000);
      bus.run = 1'b1;
      cyc();
      chk("resume_addr", 16'(bus.rom_addr), 16'h1);
      cyc(); cyc(); cyc();
      repeat (8) cyc();
      chk("wrap_pc6", 16'(bus.pc), 16'h6);
      cyc();
      chk("wrap_lo_addr", 16'(bus.rom_addr), 16'h7);
      cyc(); cyc();
      chk("mov_ctl", 16'({bus.rf_we, bus.alu_src_imm, bus.alu_op}), 16'b1_0_100);
      chk("mov_regs", 16'({bus.rf_waddr, bus.rf_raddr_a, bus.rf_raddr_b}), 16'b10_10_11);
      cyc();
      chk("wrap_pc0", 16'(bus.pc), 16'h0);
      chk("wrap_addr0", 16'(bus.rom_addr), 16'h0);

      // HLT
      load(8'hF0, 8'h00, 8'h15, 8'h07, 8'h00, 8'h00, 8'h00, 8'h00);
      do_reset();
      cyc(); cyc(); cyc();
      chk_idle("hlt_exec_idle");
      chk("hlt_exec_halted", 16'(bus.halted), 16'h0);
      for (int i = 0; i < 10; i++) begin
         cyc();
         chk($sformatf("halt_%0d", i), 16'({bus.halted, bus.pc_enable, bus.rf_we, bus.pc}), 16'({1'b1, 1'b0, 1'b0, 3'd0}));
      end

      // reset in the middle of a fetch
      load(8'h15, 8'h07, 8'h35, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
      do_reset();
      chk("halt_cleared", 16'(bus.halted), 16'h0);
      cyc(); cyc(); cyc(); cyc();
      cyc();
      chk("mid_flo_addr", 16'(bus.rom_addr), 16'h3);
      reset = 1'b1;
      #1;
      chk("mid_rst_ir", bus.ir, 16'h0000);
      chk_idle("mid_rst_idle");
      chk("mid_rst_addr", 16'(bus.rom_addr), 16'h0);
      cyc();
      reset = 1'b0;
      #1;
      chk("mid_fhi_addr", 16'(bus.rom_addr), 16'h0);
      cyc();
      chk("mid_flo_again", 16'(bus.rom_addr), 16'h1);
      cyc(); cyc();
      chk("mid_refetch_ir", bus.ir, 16'h1507);

      // illegal opcode 0xB, then LDI
      load(8'hB0, 8'h00, 8'h15, 8'h07, 8'h00, 8'h00, 8'h00, 8'h00);
      do_reset();
      cyc(); cyc(); cyc();
`ifdef CTRL_ILLEGAL_TRAP_EN
      chk_idle("ill_exec_idle");
      chk("ill_before", 16'({bus.illegal_op, bus.halted}), 16'b00);
      cyc();
      chk("ill_flags", 16'({bus.illegal_op, bus.halted}), 16'b11);
      chk("ill_pc", 16'(bus.pc), 16'h0);
      cyc(); cyc(); cyc();
      chk("ill_stuck", 16'({bus.illegal_op, bus.halted, bus.pc_enable, bus.pc}), 16'({2'b11, 1'b0, 3'd0}));
`else
      chk("ill_nop_ctl", 16'({bus.pc_enable, bus.pc_load, bus.rf_we, bus.alu_op}), 16'b1_0_0_000);
      chk("ill_flag_off", 16'({bus.illegal_op, bus.halted}), 16'b00);
      cyc();
      chk("ill_next_pc", 16'(bus.pc), 16'h2);
      cyc(); cyc(); cyc();
      chk("ill_then_ldi", 16'({bus.ir, bus.rf_we}), 16'({16'h1507, 1'b1}));
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/cpu_ctrl_fsm.md
Name: cpu_ctrl_fsm

Overview:
Instruction-sequencing controller for the 8-bit CPU. Fetches each 16-bit instruction as two bytes from byte-addressed synchronous ROM, assembles it into an instruction register, decodes it, and emits one cycle of datapath strobes. Those strobes are register-file write, ALU select, flag update, and the PC enable/load that drive the program counter (+2 increment or branch load). Sits between PC, ROM, register file and ALU; owns the ROM address bus.

Parameters:
ADDR_WIDTH, 3, ROM/PC address width in bits; all address arithmetic is modulo 2^ADDR_WIDTH.

Ports:
clk  in  1  clock, rising edge.
reset  in  1  asynchronous, active-high.
run  in  1  1 = execute; 0 = pause at instruction boundary.
pc  in  ADDR_WIDTH  current program counter value.
rom_data  in  8  ROM read data, valid 1 cycle after rom_addr.
alu_zero  in  1  ALU result == 0 (combinational from ALU).
rom_addr  out  ADDR_WIDTH  ROM byte address.
pc_enable  out  1  PC advance strobe.
pc_load  out  1  PC load strobe (valid only with pc_enable).
pc_next_value  out  ADDR_WIDTH  branch target.
ir  out  16  instruction register.
rf_we  out  1  register-file write strobe.
rf_waddr  out  2  destination register = ir[11:10].
rf_raddr_a  out  2  source A = ir[11:10].
rf_raddr_b  out  2  source B = ir[9:8].
alu_op  out  3  0 ADD, 1 SUB, 2 AND, 3 OR, 4 PASS_B.
alu_src_imm  out  1  ALU B operand = imm instead of rf B.
imm  out  8  ir[7:0].
z_flag  out  1  zero flag register.
halted  out  1  core halted.
illegal_op  out  1  illegal-opcode trap (see Optional Feature).

Behaviour:
- Format: opcode ir[15:12], rd ir[11:10], rs ir[9:8], imm ir[7:0]. High byte at pc, low byte at pc+1.
- Opcodes: 0 NOP, 1 LDI rd=imm, 2 ADD, 3 SUB, 4 AND, 5 OR (rd=rd op rs), 6 MOV rd=rs, 7 JMP, 8 JZ, 9 JNZ, F HLT, A–E illegal.
- States: FETCH_HI, FETCH_LO, DECODE, EXECUTE, HALT. Reset state FETCH_HI.
- FETCH_HI: rom_addr=pc. If run=1, go to FETCH_LO; otherwise stay, with no strobes. run is sampled only here.
- FETCH_LO: rom_addr=pc+1 (wraps). At the clock edge, ir[15:8] <= rom_data. Next state DECODE.
- DECODE: rom_addr=pc. At the clock edge, ir[7:0] <= rom_data. Next state EXECUTE.
- EXECUTE: exactly one cycle; all strobes are combinational from state+ir and are asserted only in this state.
  - pc_enable=1 for every opcode except HLT.
  - pc_load=1 for JMP, for JZ when z_flag=1, and for JNZ when z_flag=0.
  - rf_we=1 for LDI, ADD, SUB, AND, OR and MOV.
  - LDI: alu_op=PASS_B, alu_src_imm=1. MOV: alu_op=PASS_B, alu_src_imm=0.
  - z_flag <= alu_zero at the edge for ADD, SUB, AND, OR only. Otherwise z_flag holds.
  - Next state FETCH_HI, or HALT for HLT.
- Outside EXECUTE, alu_op, alu_src_imm and pc_load are 0.
- pc_next_value = {imm[ADDR_WIDTH-1:1],1'b0}. Targets are forced even. Imm bits above ADDR_WIDTH are ignored.
- Branches test z_flag as registered before the current EXECUTE edge, i.e. the result of a prior instruction.
- HALT: halted=1 (registered, set on the EXECUTE→HALT edge). No strobes. Leaves only via reset.
- Throughput: 4 cycles per instruction with run held high. PC changes exactly on the EXECUTE edge.
- Reset (any state, mid-instruction included): state=FETCH_HI, ir=0, z_flag=0, halted=0, illegal_op=0. All strobes are 0. rom_addr follows pc (0 after PC reset). A partially fetched instruction is discarded.
- Wrap: pc+1 and the PC's +2 wrap modulo 2^ADDR_WIDTH. At pc=6 with ADDR_WIDTH=3, the low byte is fetched from 7 and the next instruction comes from 0.

Optional Feature:
- Macro: CTRL_ILLEGAL_TRAP_EN.
- Defined: opcodes A–E in EXECUTE assert no strobes (pc_enable=0). They set illegal_op=1 and halted=1 (registered) and enter HALT. Both flags are cleared only by reset.
- Undefined: opcodes A–E execute as NOP (pc_enable=1, no other strobes). illegal_op is tied to 0.

Test Plan:
- Reset/fetch: ROM[0..1]=0x15,0x07 (LDI r1,7), run=1, release reset. Required: rom_addr 0 then 1; ir=0x1507 in EXECUTE; rf_we=1, rf_waddr=1, alu_src_imm=1, imm=7, pc_enable=1, pc_load=0. Next instruction at pc=2.
- Zero-flag branch: SUB with alu_zero=1, then JZ imm=0x04. Required: z_flag=1 after SUB EXECUTE; JZ EXECUTE has pc_load=1, pc_next_value=4. Repeat with alu_zero=0 → pc_load=0.
- JNZ/JMP odd target: JMP imm=0x05. Required: pc_load=1, pc_next_value=4. JNZ with z_flag=1 → pc_load=0.
- Run pause and wrap: hold run=0 for 5 cycles in FETCH_HI. Required: no strobes, state unchanged. Then run at pc=6 → low byte read from address 7, PC wraps to 0.
- HLT and mid-instruction reset: HLT executes. Required: pc_enable=0, halted=1, stays HALT for 10 cycles. Separately, assert reset during FETCH_LO → next cycle state FETCH_HI, ir=0, no strobes.
- Illegal opcode 0xB: with CTRL_ILLEGAL_TRAP_EN → illegal_op=1, halted=1, pc_enable=0. Without it → pc_enable=1, illegal_op=0, execution continues at pc+2.
